uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 1250, meaning clock cycles per bit (12 MHz / 9600 baud).
REQ-002 SHALL have localparam CW = $clog2(BAUD_DIV), the width of the bit-timing counter.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req0, input, 1 bit: requester 0 asks to send one byte.
REQ-006 SHALL have port data0, input, 8 bits: requester 0 byte, valid while req0=1.
REQ-007 SHALL have port ack0, output, 1 bit: one-cycle pulse; data0 has been captured.
REQ-008 SHALL have ports req1 (input, 1), data1 (input, 8) and ack1 (output, 1), identical in meaning to req0, data0 and ack0 for requester 1.
REQ-009 SHALL have port tx, output, 1 bit: serial line, 8N1, LSB first, idle high.
REQ-010 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-011 SHALL have port grant_id, output, 1 bit: the requester owning the current or last frame.

Function
REQ-012 SHALL use four FSM states: IDLE, START, DATA, STOP.
REQ-013 SHALL behave as follows in IDLE: if req0 or req1 is 1 at a clock edge, move to START on that edge, latch the winner's byte into an 8-bit shift register, set grant_id, pulse the winner's ack for exactly that one following cycle, and drive tx to 0 from that cycle.
REQ-014 SHALL arbitrate round-robin: when both requests are active, grant the requester not granted last; the pointer updates only on grant.
REQ-015 SHALL grant the sole active requester when only one request is active, regardless of the pointer.
REQ-016 SHALL keep the bit counter at 0 in IDLE; in the other states it SHALL count 0..BAUD_DIV-1 and wrap, with a bit-end tick when the count equals BAUD_DIV-1.
REQ-017 SHALL hold every bit on tx for exactly BAUD_DIV cycles; a frame SHALL last 10*BAUD_DIV cycles.
REQ-018 SHALL, in START, move to DATA on tick with tx = shift[0].
REQ-019 SHALL, in DATA, shift right on each tick, keep a 3-bit index, and move to STOP after the tick that ends bit 7.
REQ-020 SHALL, in STOP, drive tx = 1 and return to IDLE on tick.
REQ-021 SHALL allow a new grant in the first IDLE cycle, giving a minimum inter-frame gap of 1 idle-high cycle.
REQ-022 SHALL require each requester to hold req and data stable until it sees ack; requests outside IDLE SHALL be ignored and never lost while held.
REQ-023 SHALL drive busy = 1 in START, DATA and STOP, and busy = 0 in IDLE.
REQ-024 SHALL drive tx from a register, with no combinational path from req or data to tx.
REQ-025 SHALL reject BAUD_DIV < 2 via an elaboration-time check.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set: state IDLE, tx 1, busy 0, ack0 0, ack1 0, grant_id 0, round-robin pointer favouring requester 0, counters 0, shift register 0.
REQ-027 SHALL abort any frame in progress on reset; tx SHALL be 1 the cycle after reset is sampled, and no ack SHALL be issued during reset.
REQ-028 SHALL give reset priority over simultaneous requests.

Structure
REQ-029 SHALL place the state encoding and the default BAUD_DIV (1250) and F_CLK (12000000) constants in a shared package, uart_pkg.
REQ-030 SHALL contain one sub-module, baud_tick, holding the bit counter and tick with inputs run and clear; the FSM and arbiter SHALL stay in the top module.

Verification
REQ-031 SHALL verify, with BAUD_DIV=4: req0=1, data0=8'hA5 -> ack0 one pulse; tx reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy high 40 cycles.
REQ-032 SHALL verify: req0 and req1 rise on the same cycle with data 8'h11 and 8'h22 -> ack0 first with 8'h11 sent, then ack1 with 8'h22; gap of 1 idle cycle.
REQ-033 SHALL verify: req1 held permanently with req0 pulsed each frame -> grants alternate 0,1,0,1 and neither requester starves.
REQ-034 SHALL verify: rst asserted for 1 cycle mid-DATA (cycle 18 of a frame) -> tx=1 and busy=0 the next cycle; a following req0 with 8'h3C sends a clean full frame.
REQ-035 SHALL verify: req1 asserted during an active frame -> no ack1 until STOP ends; ack1 in the first IDLE cycle.
REQ-036 SHALL verify, with BAUD_DIV=1250: data 8'h55 -> each bit width is exactly 1250 cycles and the frame is 12500 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the scheduled UART transmitter.
package uart_pkg;

    localparam int F_CLK        = 12000000;
    localparam int DEF_BAUD_DIV = 1250;     // 12 MHz / 9600 baud

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/baud_tick.sv
// Bit-timing counter: counts 0..BAUD_DIV-1 while run is high and flags the last
// cycle of each bit period. It is held at zero while idle so every frame starts
// on a fresh bit boundary.
module baud_tick #(
    parameter int BAUD_DIV = 1250
) (
    input  logic clk,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-run within a frame and wrap on the bit end; park at zero otherwise.
    always_ff @(posedge clk) begin
        if (clear || !run)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester 8N1 UART transmitter with round-robin arbitration. A byte is
// captured and acknowledged in the IDLE cycle it is seen, so requesters only
// need to hold req/data until their ack pulse.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_tx_sched: BAUD_DIV must be at least 2");
    end

    tx_state_e  state, state_n;
    logic [7:0] shift_q, shift_n;
    logic [2:0] idx_q, idx_n;
    logic       tx_n, ack0_n, ack1_n, gid_n;
    logic       rr_q, rr_n;     // id of the requester preferred on contention
    logic       win;
    logic       tick;

    baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .run   (state != IDLE),
        .clear (rst),
        .tick  (tick)
    );

    // Winner: the preferred id under contention, otherwise whoever is asking.
    always_comb begin
        win = 1'b0;
        if (req0 && req1)
            win = rr_q;
        else
            win = req1;
    end

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        idx_n   = idx_q;
        tx_n    = tx;
        ack0_n  = 1'b0;
        ack1_n  = 1'b0;
        gid_n   = grant_id;
        rr_n    = rr_q;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_n = START;
                    shift_n = win ? data1 : data0;
                    gid_n   = win;
                    rr_n    = ~win;
                    ack0_n  = ~win;
                    ack1_n  = win;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    tx_n    = shift_q[0];
                    idx_n   = 3'd0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = {1'b0, shift_q[7:1]};
                    idx_n   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        tx_n    = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (tick)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            tx       <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            grant_id <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            state    <= state_n;
            shift_q  <= shift_n;
            idx_q    <= idx_n;
            tx       <= tx_n;
            ack0     <= ack0_n;
            ack1     <= ack1_n;
            grant_id <= gid_n;
            rr_q     <= rr_n;
        end
    end

    assign busy = (state != IDLE);

endmodule
